// File: rtl/ff_pkg.sv
// Shared mode encoding and per-bit next-state rule for the multi-mode flip-flop bank.
package ff_pkg;

  typedef enum logic [1:0] {FF_D, FF_T, FF_JK, FF_SR} ff_mode_e;

  // SR with S=R=1 holds the bit; the illegal condition is flagged separately.
  function automatic logic ff_next(ff_mode_e mode, logic a, logic b, logic q);
    logic nxt;
    nxt = q;
    case (mode)
      FF_D:  nxt = a;
      FF_T:  nxt = q ^ a;
      FF_JK: nxt = (a & ~q) | (~b & q);
      FF_SR: begin
        if (a && !b)      nxt = 1'b1;
        else if (!a && b) nxt = 1'b0;
        else              nxt = q;
      end
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ff_cell.sv
// One mode-configurable flip-flop bit with enable, synchronous reset and a registered change pulse.
module ff_cell
  import ff_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rst_val,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  output logic       q,
  output logic       chg,
  output logic       sr_illegal
);

  ff_mode_e mode_e;
  logic     q_next;

  always_comb begin
    mode_e     = ff_mode_e'(mode);
    q_next     = ff_next(mode_e, a, b, q);
    sr_illegal = en & (mode_e == FF_SR) & a & b;
  end

  // The change pulse compares against the value being replaced, so it is 0 whenever the bit holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= rst_val;
      chg <= 1'b0;
    end else if (en) begin
      q   <= q_next;
      chg <= q_next ^ q;
    end else begin
      chg <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_mode_ff_bank.sv
// WIDTH-bit register whose bits behave as D, T, JK or SR flip-flops, with a sticky illegal-SR error flag.
module multi_mode_ff_bank
  import ff_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             err_clr_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] qn_o,
  output logic [WIDTH-1:0] chg_o,
  output logic             err_o
);

  logic [WIDTH-1:0] sr_illegal;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ff_cell u_cell (
      .clk        (clk),
      .rst        (rst),
      .rst_val    (RST_VAL[i]),
      .en         (en_i),
      .mode       (mode_i),
      .a          (a_i[i]),
      .b          (b_i[i]),
      .q          (q_o[i]),
      .chg        (chg_o[i]),
      .sr_illegal (sr_illegal[i])
    );
  end

  assign qn_o = ~q_o;

  // A new illegal event outranks a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_o <= 1'b0;
    end else if (|sr_illegal) begin
      err_o <= 1'b1;
    end else if (err_clr_i) begin
      err_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Directed self-checking bench for multi_mode_ff_bank (WIDTH=8, RST_VAL=8'hA5).
module tb_multi_mode_ff_bank;

  localparam int         WIDTH   = 8;
  localparam logic [7:0] RST_VAL = 8'hA5;
  localparam logic [1:0] M_D  = 2'b00;
  localparam logic [1:0] M_T  = 2'b01;
  localparam logic [1:0] M_JK = 2'b10;
  localparam logic [1:0] M_SR = 2'b11;

  logic             clk = 1'b0;
  logic             rst;
  logic             en_i;
  logic [1:0]       mode_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             err_clr_i;
  logic [WIDTH-1:0] q_o;
  logic [WIDTH-1:0] qn_o;
  logic [WIDTH-1:0] chg_o;
  logic             err_o;

  int check_count = 0;
  int pass_count  = 0;

  multi_mode_ff_bank #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) dut (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en_i),
    .mode_i    (mode_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .err_clr_i (err_clr_i),
    .q_o       (q_o),
    .qn_o      (qn_o),
    .chg_o     (chg_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge happen, then sample 1 time unit later.
  task automatic applyStimulus(input logic r, input logic en, input logic [1:0] mode,
                               input logic [7:0] a, input logic [7:0] b, input logic clr);
    rst       = r;
    en_i      = en;
    mode_i    = mode;
    a_i       = a;
    b_i       = b;
    err_clr_i = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic checkBank(input string tag, input logic [7:0] q, input logic [7:0] chg,
                           input logic err);
    checkOutput({tag, " q"},   {24'd0, q_o},   {24'd0, q});
    checkOutput({tag, " qn"},  {24'd0, qn_o},  {24'd0, ~q});
    checkOutput({tag, " chg"}, {24'd0, chg_o}, {24'd0, chg});
    checkOutput({tag, " err"}, {31'd0, err_o}, {31'd0, err});
  endtask

  initial begin
    rst = 1'b1; en_i = 1'b0; mode_i = M_D; a_i = '0; b_i = '0; err_clr_i = 1'b0;
    @(negedge clk);

    applyStimulus(1, 0, M_D, 8'h00, 8'h00, 0);
    applyStimulus(1, 0, M_D, 8'h00, 8'h00, 0);
    checkBank("reset", 8'hA5, 8'h00, 0);

    applyStimulus(0, 1, M_D, 8'h3C, 8'h00, 0);
    checkBank("d_load", 8'h3C, 8'h99, 0);
    applyStimulus(0, 0, M_D, 8'hFF, 8'h00, 0);
    checkBank("d_hold", 8'h3C, 8'h00, 0);

    applyStimulus(0, 1, M_D, 8'h00, 8'h00, 0);
    checkBank("d_zero", 8'h00, 8'h3C, 0);
    applyStimulus(0, 1, M_T, 8'h0F, 8'h00, 0);
    checkBank("t_1", 8'h0F, 8'h0F, 0);
    applyStimulus(0, 1, M_T, 8'h0F, 8'h00, 0);
    checkBank("t_2", 8'h00, 8'h0F, 0);
    applyStimulus(0, 1, M_T, 8'h0F, 8'h00, 0);
    checkBank("t_3", 8'h0F, 8'h0F, 0);

    // F0 under J=CC, K=AA: hold/clear/set/toggle per bit pair gives 5C.
    applyStimulus(0, 1, M_D, 8'hF0, 8'h00, 0);
    checkBank("d_f0", 8'hF0, 8'hFF, 0);
    applyStimulus(0, 1, M_JK, 8'hCC, 8'hAA, 0);
    checkBank("jk", 8'h5C, 8'hAC, 0);

    applyStimulus(0, 1, M_SR, 8'h81, 8'h01, 0);
    checkBank("sr_illegal", 8'hDC, 8'h80, 1);
    applyStimulus(0, 1, M_SR, 8'h00, 8'h00, 1);
    checkBank("sr_clear", 8'hDC, 8'h00, 0);
    applyStimulus(0, 1, M_SR, 8'h01, 8'h01, 0);
    checkBank("sr_reset_err", 8'hDC, 8'h00, 1);
    applyStimulus(0, 1, M_SR, 8'h01, 8'h01, 1);
    checkBank("sr_set_wins", 8'hDC, 8'h00, 1);
    applyStimulus(0, 1, M_SR, 8'h00, 8'h00, 1);
    checkBank("sr_clear2", 8'hDC, 8'h00, 0);
    applyStimulus(0, 0, M_SR, 8'hFF, 8'hFF, 0);
    checkBank("sr_disabled", 8'hDC, 8'h00, 0);
    applyStimulus(0, 1, M_SR, 8'h02, 8'h10, 0);
    checkBank("sr_set_clr", 8'hCE, 8'h12, 0);

    applyStimulus(0, 1, M_D, 8'h00, 8'h00, 0);
    checkBank("pre_mid", 8'h00, 8'hCE, 0);
    applyStimulus(0, 1, M_SR, 8'h01, 8'h01, 0);
    checkBank("arm_err", 8'h00, 8'h00, 1);
    applyStimulus(0, 1, M_T, 8'hFF, 8'h00, 0);
    checkBank("t_run", 8'hFF, 8'hFF, 1);
    applyStimulus(1, 1, M_T, 8'hFF, 8'h00, 0);
    checkBank("mid_reset", 8'hA5, 8'h00, 0);
    applyStimulus(0, 1, M_T, 8'hFF, 8'h00, 0);
    checkBank("t_resume", 8'h5A, 8'hFF, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
